// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, direction encodings and scheduler state shared by the intersection controllers
package traffic_pkg;
  localparam logic [1:0] LIGHT_RED = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN = 2'b10;
  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;
  typedef enum logic [1:0] {ST_ALLRED, ST_GREEN, ST_YELLOW} state_e;
  function automatic logic [3:0] dir_bit(input logic [1:0] d);
    return 4'b1000 >> d;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: restartable prescaler; clk/rst_n/restart in, tick out once every TICK_DIV cycles
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] TOP = W'(TICK_DIV - 1);
  logic [W-1:0] cnt_q;
  assign tick = cnt_q == TOP;
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= (restart || tick) ? '0 : cnt_q + W'(1);
endmodule

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: round-robin N/E/S/W phase scheduler with preempt; req/preempt_vld/preempt_dir in, lights/phase/preempt_ack out
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 15,
  parameter int YELLOW    = 1,
  parameter int ALL_RED   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       preempt_vld,
  input  logic [1:0] preempt_dir,
  output logic [7:0] lights,
  output logic [1:0] phase,
  output logic       preempt_ack
);
  localparam logic [4:0] MIN_L = 5'(MIN_GREEN);
  localparam logic [4:0] MAX_L = 5'(MAX_GREEN);
  localparam logic [4:0] YEL_L = 5'(YELLOW);
  localparam logic [4:0] AR_L  = 5'(ALL_RED);
  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d, last_q, last_d, pick, code;
  logic [3:0] pending_q, pending_d;
  logic [4:0] el_q, el_d, el_nx;
  logic       done_q, ack_q, ack_d, tick, restart, pick_vld, others;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .restart(restart),
    .tick(tick)
  );
  // i = 4 wraps back to last itself, so the loop leaves the nearest successor of last in pick
  always_comb begin
    pick = last_q;
    pick_vld = 1'b0;
    for (int i = 4; i >= 1; i--)
      if (|(pending_q & dir_bit(2'(last_q + 2'(i))))) begin
        pick = 2'(last_q + 2'(i));
        pick_vld = 1'b1;
      end
  end
  assign el_nx = (tick && el_q != 5'd31) ? el_q + 5'd1 : el_q;
  assign others = |(pending_q & ~dir_bit(phase_q));
  // done_q stands in for an expired clearance right after reset, when el_q is still 0
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_ALLRED:
        if ((done_q || el_nx >= AR_L) && (preempt_vld || pick_vld)) begin
          state_d = ST_GREEN;
          phase_d = preempt_vld ? preempt_dir : pick;
        end
      ST_GREEN:
        state_d = (preempt_vld ? preempt_dir != phase_q
                               : others && (el_nx >= MIN_L || el_nx >= MAX_L)) ? ST_YELLOW : ST_GREEN;
      ST_YELLOW: state_d = el_nx >= YEL_L ? ST_ALLRED : ST_YELLOW;
      default:   state_d = ST_ALLRED;
    endcase
  end
  assign restart   = state_d != state_q;
  assign el_d      = restart ? 5'd0 : el_nx;
  assign last_d    = (state_q == ST_ALLRED && state_d == ST_GREEN) ? phase_d : last_q;
  assign pending_d = (pending_q | req) & ~(state_d == ST_GREEN ? dir_bit(phase_d) : 4'b0);
  assign ack_d     = state_d == ST_GREEN && preempt_vld && preempt_dir == phase_d;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q   <= ST_ALLRED;
      phase_q   <= DIR_N;
      last_q    <= DIR_W;
      pending_q <= 4'b0;
      el_q      <= 5'd0;
      done_q    <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      last_q    <= last_d;
      pending_q <= pending_d;
      el_q      <= el_d;
      done_q    <= done_q & ~restart;
      ack_q     <= ack_d;
    end
  assign code = state_q == ST_GREEN ? LIGHT_GREEN : state_q == ST_YELLOW ? LIGHT_YELLOW : LIGHT_RED;
  assign lights = {6'b0, code} << {2'd3 - phase_q, 1'b0};
  assign phase = phase_q;
  assign preempt_ack = ack_q;
endmodule

// File: tb/tb_traffic_phase_sched.sv
// tb_traffic_phase_sched: directed checks of phase order, green/yellow/all-red timing, preempt and reset
module tb_traffic_phase_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       preempt_vld = 1'b0;
  logic [3:0] req = 4'b0;
  logic [1:0] preempt_dir = 2'd0;
  logic [7:0] lights;
  logic [1:0] phase;
  logic       preempt_ack;
  int checks = 0;
  int failures = 0;
  traffic_phase_sched #(
    .TICK_DIV(4), .MIN_GREEN(2), .MAX_GREEN(4), .YELLOW(1), .ALL_RED(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .preempt_vld(preempt_vld),
    .preempt_dir(preempt_dir),
    .lights(lights),
    .phase(phase),
    .preempt_ack(preempt_ack)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic hold(input string tag, input logic [7:0] val, input int n);
    logic [7:0] got;
    got = val;
    for (int i = 0; i < n; i++) begin
      if (lights !== val && got === val) got = lights;
      @(negedge clk);
    end
    check(tag, {24'b0, got}, {24'b0, val});
  endtask
  task automatic do_reset(input logic [3:0] r);
    rst_n = 1'b0;
    req = r;
    preempt_vld = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask
  initial begin
    do_reset(4'b0000);
    hold("t1_idle", 8'h00, 100);
    check("t1_phase", phase, 0);
    check("t1_ack", preempt_ack, 0);
    req = 4'b1000; step(1); req = 4'b0000; step(1);
    check("t2_n_green", lights, 8'h80);
    hold("t2_rest", 8'h80, 100);
    check("t2_phase", phase, 0);
    do_reset(4'b0000);
    req = 4'b1000; step(1); req = 4'b0000; step(1);
    check("t3_n_green", lights, 8'h80);
    req = 4'b0100; step(1); req = 4'b0000;
    hold("t3_n_hold", 8'h80, 7);
    hold("t3_n_yel", 8'h40, 4);
    hold("t3_allred", 8'h00, 4);
    check("t3_e_green", lights, 8'h20);
    check("t3_phase", phase, 1);
    do_reset(4'hF);
    step(2);
    for (int d = 0; d < 4; d++) begin
      hold($sformatf("t4_green%0d", d), 8'h80 >> (2 * d), 8);
      hold($sformatf("t4_yel%0d", d), 8'h40 >> (2 * d), 4);
      hold($sformatf("t4_red%0d", d), 8'h00, 4);
    end
    check("t4_wrap_n", lights, 8'h80);
    req = 4'b0000;
    do_reset(4'b0000);
    req = 4'b1000; step(1); req = 4'b0000; step(1);
    check("t5_n_green", lights, 8'h80);
    check("t5_ack_idle", preempt_ack, 0);
    preempt_vld = 1'b1; preempt_dir = 2'd2; step(1);
    hold("t5_n_yel", 8'h40, 4);
    hold("t5_allred", 8'h00, 4);
    check("t5_s_green", lights, 8'h08);
    check("t5_ack", preempt_ack, 1);
    req = 4'b0100; step(1); req = 4'b0000;
    hold("t5_s_hold", 8'h08, 40);
    check("t5_ack_hold", preempt_ack, 1);
    preempt_vld = 1'b0; step(1);
    check("t5_s_yel", lights, 8'h04);
    check("t5_ack_drop", preempt_ack, 0);
    hold("t5_s_yel_hold", 8'h04, 4);
    hold("t5_allred2", 8'h00, 4);
    check("t5_e_green", lights, 8'h20);
    check("t5_phase", phase, 1);
    req = 4'b0010; step(1); req = 4'b0000;
    hold("t6_e_green", 8'h20, 7);
    check("t6_e_yel", lights, 8'h10);
    rst_n = 1'b0; step(1);
    check("t6_reset_lights", lights, 8'h00);
    check("t6_reset_phase", phase, 0);
    rst_n = 1'b1;
    hold("t6_no_grant", 8'h00, 20);
    req = 4'b1010; step(1); req = 4'b0000; step(1);
    check("t6_n_first", lights, 8'h80);
    check("t6_phase", phase, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/traffic_phase_sched.md
# traffic_phase_sched

Demand-responsive phase scheduler for the four-way intersection. It arbitrates vehicle requests from the North, East, South and West approaches and grants one approach at a time. Each grant runs the sequence green, yellow, all-red. An emergency preempt overrides the round-robin order. It drives the same 2-bit-per-direction light bus as the fixed-time controller and replaces that controller's timer-only sequencing at the top level.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per timing tick (1 s at 50 MHz); must be ≥ 2.
- `MIN_GREEN`, default 5: minimum green duration in ticks, 1..31.
- `MAX_GREEN`, default 15: green duration, in ticks, after which a contested green is forced to end; must satisfy MIN_GREEN ≤ MAX_GREEN ≤ 31.
- `YELLOW`, default 1: yellow duration in ticks, 1..31.
- `ALL_RED`, default 1: all-red clearance duration in ticks, 1..31.

Ports:
- `clk` input, 1 bit: single clock; the only clock.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `req` input, 4 bits: {N,E,S,W} vehicle detector requests; a level or a single-cycle pulse is sufficient.
- `preempt_vld` input, 1 bit: emergency preempt request.
- `preempt_dir` input, 2 bits: preempt direction; 0=N, 1=E, 2=S, 3=W. Sampled while `preempt_vld` is high.
- `lights` output, 8 bits: {N,E,S,W}, 2 bits per direction; red=00, yellow=01, green=10.
- `phase` output, 2 bits: direction currently or most recently granted.
- `preempt_ack` output, 1 bit: high while `preempt_dir` is green and `preempt_vld` is high.

## Operation
- States:
  - ALLRED: all lights 00.
  - GREEN: `phase` direction shows 10, others 00.
  - YELLOW: `phase` direction shows 01, others 00.
- Reset values:
  - state = ALLRED, with its ALL_RED clearance treated as already expired.
  - `lights` = 8'h00, `phase` = 0, `preempt_ack` = 0.
  - `pending` = 0.
  - `last` = 3 (W), so N wins the first round-robin.
  - elapsed-tick counter = 0.
- Pending requests:
  - `pending[d]` sets on any cycle `req[d]` = 1.
  - It clears on the cycle direction d enters GREEN.
  - If set and clear coincide, clear wins; a request arriving while d is already green is not retained.
- ALLRED to GREEN, evaluated once clearance has expired:
  - If `preempt_vld` is high, grant `preempt_dir`.
  - Otherwise, grant the first pending direction after `last` in the order N→E→S→W→N.
  - If nothing is pending, stay in ALLRED and re-evaluate every cycle.
- On GREEN entry: `phase` and `last` become the granted direction.
- GREEN to YELLOW; "others pending" means any `pending` bit other than `phase`:
  - Leave when elapsed ≥ MIN_GREEN and others are pending.
  - Leave at elapsed = MAX_GREEN if others are pending.
  - If no others are pending, rest in green indefinitely; the elapsed counter saturates at 31.
  - Preempt for another direction: leave immediately on the next cycle, waiving MIN_GREEN.
  - Preempt for the phase direction: hold green regardless of MIN/MAX while `preempt_vld` stays high.
- YELLOW to ALLRED: at elapsed = YELLOW. Not interruptible by preempt.
- ALLRED exit: once elapsed reaches ALL_RED, arbitrate as above.
- Outputs: decoded from registered state and `phase` only. There is no combinational path from any input to any output.
- Reset mid-operation: `rst_n` low at an edge restores all reset values on that edge, irrespective of state or preempt.

## Timing
- Tick generation:
  - An internal prescaler counts 0..TICK_DIV−1 and pulses `tick` as it wraps.
  - The prescaler restarts at 0 on every state transition, so each tick period within a state is exactly TICK_DIV cycles.
- Elapsed-tick counter: 5 bits, cleared on state entry, incremented on `tick`.
- Transition condition: true in the cycle where `tick` takes elapsed to N; the state flop updates at the next edge.
- Resulting durations:
  - YELLOW lasts exactly YELLOW×TICK_DIV cycles.
  - ALLRED lasts exactly ALL_RED×TICK_DIV cycles.
  - A contested green lasts MIN_GREEN×TICK_DIV cycles when the competing request is pending before that point.
- Request latency: `req` pulse at cycle t is visible in `pending` at t+1.
- Preempt latency: `preempt_vld` high at cycle t during another direction's GREEN gives YELLOW at t+1.

## Structure
- Shared package or include `traffic_pkg` holds:
  - Light codes: RED, YELLOW, GREEN.
  - Direction encodings: N, E, S, W.
  - The scheduler state encoding.
- The fixed-time controller uses the same light codes.
- Sub-module `tick_gen`: the prescaler, with a `restart` input and a `tick` output, parameterized by TICK_DIV.
- The round-robin picker stays inline.

## Test plan
Bench parameters: TICK_DIV=4, MIN_GREEN=2, MAX_GREEN=4, YELLOW=1, ALL_RED=1.

1. Reset with no requests for 100 cycles → `lights` = 8'h00 throughout; `phase` = 0; `preempt_ack` = 0.
2. `req` = 4'b1000 pulse → N green, `lights` = 8'h80, within 2 cycles; green holds for 100+ cycles with no other request.
3. N green at elapsed 0, `req` E pulse → N green for 8 cycles total, then 8'h40 for 4 cycles, then 8'h00 for 4 cycles, then 8'h20.
4. `req` = 4'hF held from reset → greens in order N, E, S, W, N, each lasting 8 cycles, separated by 4 yellow and 4 all-red cycles.
5. N green, `preempt_vld` = 1 with `preempt_dir` = 2 at cycle t:
   - 8'h40 at t+1, then 8'h00, then 8'h08 with `preempt_ack` = 1.
   - S green is held for 40 cycles while `preempt_vld` stays high.
   - After `preempt_vld` is dropped, with E pending: S yellow within 8 cycles.
6. `rst_n` low for one edge mid-YELLOW with `pending` nonzero → next cycle `lights` = 8'h00, `pending` = 0, and the next grant goes to N.
